// File: rtl/rdx4_input_gather_pkg.sv
// Shared constants and helpers for the radix-4 input gather block.
// Sample width math, address width helper and FSM state encoding.
package rdx4_pkg;

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    function automatic int dw_calc(input int s, input int i, input int f);
        return s + i + f;
    endfunction

    function automatic int clog2(input int v);
        return $clog2(v);
    endfunction

endpackage

// File: rtl/rdx4_input_gather_if.sv
// Serial sample stream in, parallel quadruple stream out.
// The gather block uses the slave view; its driver uses master.
interface rdx4_input_gather_if #(
    parameter int DW = 13
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_re;
    logic [DW-1:0] s_im;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [DW-1:0] out1_re;
    logic [DW-1:0] out1_im;
    logic [DW-1:0] out2_re;
    logic [DW-1:0] out2_im;
    logic [DW-1:0] out3_re;
    logic [DW-1:0] out3_im;
    logic [DW-1:0] out4_re;
    logic [DW-1:0] out4_im;

    modport slave (
        input  s_valid, s_re, s_im, m_ready,
        output s_ready, m_valid, m_last,
        output out1_re, out1_im, out2_re, out2_im,
        output out3_re, out3_im, out4_re, out4_im
    );

    modport master (
        output s_valid, s_re, s_im, m_ready,
        input  s_ready, m_valid, m_last,
        input  out1_re, out1_im, out2_re, out2_im,
        input  out3_re, out3_im, out4_re, out4_im
    );
endinterface

// File: rtl/rdx4_input_gather_bank.sv
// One quarter-frame bank: single write port, registered read.
// The read register doubles as the block's output holding stage.
module rdx4_bank #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    // storage write, contents intentionally not reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // read register only advances when a new quadruple is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/rdx4_input_gather.sv
// Radix-4 input gather: fill a frame serially, then drain
// quadruples x[k], x[k+Q], x[k+2Q], x[k+3Q] in parallel.
module rdx4_input_gather
    import rdx4_pkg::*;
#(
    parameter int SIGN_BIT = 1,
    parameter int INT_BIT  = 6,
    parameter int FLT_BIT  = 6,
    parameter int N        = 64
) (
    input logic                clk,
    input logic                rst_n,
    rdx4_input_gather_if.slave bus
);
    localparam int DW = dw_calc(SIGN_BIT, INT_BIT, FLT_BIT);
    localparam int Q  = N / 4;
    localparam int AW = clog2(Q);

    logic [0:0]    state;
    logic [0:0]    nxt_state;
    logic [AW+1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic          s_ready_q;
    logic          m_valid_q;
    logic          m_last_q;
    logic          accept;
    logic          wr_end;
    logic          load;
    logic          fin;
    logic [2*DW-1:0] rd [4];

    assign accept = (state == FILL) && bus.s_valid && s_ready_q;
    assign wr_end = accept && (wr_cnt == (AW+2)'(N-1));
    assign fin    = m_valid_q && bus.m_ready && m_last_q;
    assign load   = (state == DRAIN) &&
                    (!m_valid_q || (bus.m_ready && !m_last_q));

    // next state: leave FILL on the last sample, DRAIN on the last transfer
    always_comb begin
        nxt_state = state;
        if (wr_end) nxt_state = DRAIN;
        if (fin)    nxt_state = FILL;
    end

    // FSM, counters and output handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state     <= nxt_state;
            s_ready_q <= (nxt_state == FILL);
            if (accept) wr_cnt <= wr_cnt + 1'b1;
            if (load) begin
                rd_cnt    <= rd_cnt + 1'b1;
                m_valid_q <= 1'b1;
                m_last_q  <= (rd_cnt == AW'(Q-1));
            end
            if (fin) begin
                rd_cnt    <= '0;
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

    for (genvar j = 0; j < 4; j++) begin : g_bank
        logic we;
        assign we = accept && (wr_cnt[AW+1 -: 2] == 2'(j));
        rdx4_bank #(
            .DEPTH (Q),
            .AW    (AW),
            .W     (2*DW)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we),
            .waddr (wr_cnt[AW-1:0]),
            .wdata ({bus.s_re, bus.s_im}),
            .re    (load),
            .raddr (rd_cnt),
            .rdata (rd[j])
        );
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign bus.out1_re = rd[0][2*DW-1:DW];
    assign bus.out1_im = rd[0][DW-1:0];
    assign bus.out2_re = rd[1][2*DW-1:DW];
    assign bus.out2_im = rd[1][DW-1:0];
    assign bus.out3_re = rd[2][2*DW-1:DW];
    assign bus.out3_im = rd[2][DW-1:0];
    assign bus.out4_re = rd[3][2*DW-1:DW];
    assign bus.out4_im = rd[3][DW-1:0];
endmodule
